ls_quad_gate_tester: RTL and testbench

LS_QUAD_GATE_TESTER -- requirements
Module: ls_quad_gate_tester

---
 rtl/ls_tester_pkg.sv | 47 ++++
 rtl/ls_quad_gate_tester_if.sv | 10 +
 rtl/ls_sync2.sv | 22 ++
 rtl/ls_quad_gate_tester.sv | 110 +++++++++++
 tb/tb_ls_quad_gate_tester.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/ls_tester_pkg.sv
// Shared types and constants for the LS quad 2-input gate tester.
// Holds the FSM encoding, the 17-entry vector table and the expected-output helper.
package ls_tester_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } vec_t;

    localparam int         NUM_VECTORS = 17;
    localparam logic [4:0] LAST_VEC    = 5'(NUM_VECTORS - 1);
    localparam logic [3:0] SIM_VEC_A   = 4'b0101;
    localparam logic [3:0] SIM_VEC_B   = 4'b1101;
    localparam logic [3:0] LS00_FUNC   = 4'b0111;
    localparam logic [4:0] NO_FAIL     = 5'h1F;

    // Vectors 0..15 walk one gate through its four input pairs; the last drives all gates.
    function automatic vec_t vector_at(input logic [4:0] n);
        vec_t v;
        v = '0;
        if (n < LAST_VEC) begin
            v.a[n[3:2]] = n[1];
            v.b[n[3:2]] = n[0];
        end else begin
            v.a = SIM_VEC_A;
            v.b = SIM_VEC_B;
        end
        return v;
    endfunction

    function automatic logic [3:0] expected_y(input logic [3:0] func, input vec_t v);
        logic [3:0] y;
        y = '0;
        for (int g = 0; g < 4; g++) begin
            y[g] = func[{v.a[g], v.b[g]}];
        end
        return y;
    endfunction

endpackage

// File: rtl/ls_quad_gate_tester_if.sv
// Pin bundle between the tester and the quad gate under test.
// The tester drives the A/B inputs and senses the four Y outputs.
interface ls_quad_gate_tester_if;
    logic [3:0] drive_a;
    logic [3:0] drive_b;
    logic [3:0] sense_y;

    modport master (output drive_a, output drive_b, input sense_y);
    modport slave  (input drive_a, input drive_b, output sense_y);
endinterface

// File: rtl/ls_sync2.sv
// Two-flop synchronizer for signals arriving asynchronously to clk.
// Synchronous active-high reset clears both stages.
module ls_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ls_quad_gate_tester.sv
// Functional tester for a quad 2-input logic gate: applies 17 vectors, waits to settle,
// compares the synchronized outputs against GATE_FUNC and reports per-gate failures.
module ls_quad_gate_tester
    import ls_tester_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [3:0] GATE_FUNC     = LS00_FUNC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    ls_quad_gate_tester_if.master    gate,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [3:0]               fail_gate,
    output logic [4:0]               first_fail_vec
);
    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state, state_nx;
    logic [4:0] n, n_nx;
    logic [7:0] cnt, cnt_nx;
    vec_t       drv, drv_nx;
    logic [3:0] fail_nx;
    logic [4:0] ffv_nx;
    logic       pass_nx;
    logic [3:0] sense_s;
    logic [3:0] mism;

    ls_sync2 #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gate.sense_y),
        .q   (sense_s)
    );

    assign gate.drive_a = drv.a;
    assign gate.drive_b = drv.b;
    assign busy = (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);

    // Expected values follow the vector currently on the pins, idle gates included.
    assign mism = sense_s ^ expected_y(GATE_FUNC, drv);

    always_comb begin
        state_nx = state;
        n_nx     = n;
        cnt_nx   = cnt;
        drv_nx   = drv;
        fail_nx  = fail_gate;
        ffv_nx   = first_fail_vec;
        pass_nx  = pass;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SETTLE;
                    n_nx     = '0;
                    cnt_nx   = CNT_LOAD;
                    drv_nx   = vector_at(5'd0);
                    fail_nx  = '0;
                    ffv_nx   = NO_FAIL;
                    pass_nx  = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt == 8'd0) state_nx = CHECK;
                else             cnt_nx   = cnt - 8'd1;
            end
            CHECK: begin
                fail_nx = fail_gate | mism;
                if (mism != 4'd0 && first_fail_vec == NO_FAIL) ffv_nx = n;
                if (n == LAST_VEC) begin
                    state_nx = DONE;
                    drv_nx   = '0;
                    pass_nx  = (fail_nx == 4'd0);
                end else begin
                    state_nx = SETTLE;
                    n_nx     = n + 5'd1;
                    cnt_nx   = CNT_LOAD;
                    drv_nx   = vector_at(n + 5'd1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            n              <= '0;
            cnt            <= '0;
            drv            <= '0;
            fail_gate      <= '0;
            first_fail_vec <= NO_FAIL;
            pass           <= 1'b0;
        end else begin
            state          <= state_nx;
            n              <= n_nx;
            cnt            <= cnt_nx;
            drv            <= drv_nx;
            fail_gate      <= fail_nx;
            first_fail_vec <= ffv_nx;
            pass           <= pass_nx;
        end
    end
endmodule

// File: tb/tb_ls_quad_gate_tester.sv
// Directed bench: behavioural quad-NAND fixtures (good, stuck, swapped, delayed)
// around a default tester, plus an AND-configured tester against a good NAND.
module tb_ls_quad_gate_tester;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic [1:0] mode = 2'd0;
    int         compared = 0;
    int         mismatched = 0;

    logic       busy, done, pass;
    logic [3:0] fail_gate;
    logic [4:0] first_fail_vec;
    logic       busy2, done2, pass2;
    logic [3:0] fail_gate2;
    logic [4:0] first_fail_vec2;

    logic [3:0] good, d1, d2;

    ls_quad_gate_tester_if gif ();
    ls_quad_gate_tester_if gif2 ();

    always #5 clk = ~clk;

    // Fixture modes: 0 good NAND, 1 gate3 Y stuck-at-1, 2 gate1/gate2 Y swapped, 3 two-clock delay
    assign good = ~(gif.drive_a & gif.drive_b);
    always @(posedge clk) begin
        d1 <= good;
        d2 <= d1;
    end
    assign gif.sense_y = (mode == 2'd1) ? (good | 4'b0100) :
                         (mode == 2'd2) ? {good[3:2], good[0], good[1]} :
                         (mode == 2'd3) ? d2 : good;
    assign gif2.sense_y = ~(gif2.drive_a & gif2.drive_b);

    ls_quad_gate_tester u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .gate           (gif),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_gate      (fail_gate),
        .first_fail_vec (first_fail_vec)
    );

    ls_quad_gate_tester #(.SETTLE_CYCLES(4), .GATE_FUNC(4'b1000)) u_and (
        .clk            (clk),
        .rst            (rst),
        .start          (start2),
        .gate           (gif2),
        .busy           (busy2),
        .done           (done2),
        .pass           (pass2),
        .fail_gate      (fail_gate2),
        .first_fail_vec (first_fail_vec2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " pass"}, 32'(pass), 32'd0);
        chk({tag, " fail_gate"}, 32'(fail_gate), 32'h0);
        chk({tag, " first_fail_vec"}, 32'(first_fail_vec), 32'h1F);
        chk({tag, " drive"}, {24'd0, gif.drive_a, gif.drive_b}, 32'h0);
    endtask

    // Sample k is taken on the falling edge after rising edge T+k, T being the start edge.
    // done must be seen at k=85, i.e. in the cycle closed by edge T+86.
    task automatic run(input string tag, input int p1, input int p2,
                       input logic exp_pass, input logic [3:0] exp_fg, input logic [4:0] exp_ffv);
        int got;
        got = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 200 && got < 0; k++) begin
            if (k > 0) @(negedge clk);
            start = ((p1 > 0 && k == p1 - 1) || (p2 > 0 && k == p2 - 1));
            if (k == 0) begin
                chk({tag, " busy@0"}, 32'(busy), 32'd1);
                chk({tag, " cleared fail_gate@0"}, 32'(fail_gate), 32'h0);
                chk({tag, " cleared ffv@0"}, 32'(first_fail_vec), 32'h1F);
            end
            if (k == 5)  chk({tag, " vec1"},  {24'd0, gif.drive_a, gif.drive_b}, 32'h01);
            if (k == 35) chk({tag, " vec7"},  {24'd0, gif.drive_a, gif.drive_b}, 32'h22);
            if (k == 80) chk({tag, " vec16"}, {24'd0, gif.drive_a, gif.drive_b}, 32'h5D);
            if (k == 84) chk({tag, " busy@84"}, 32'(busy), 32'd1);
            if (done) got = k;
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(got), 32'd85);
        chk({tag, " busy@done"}, 32'(busy), 32'd0);
        chk({tag, " drive@done"}, {24'd0, gif.drive_a, gif.drive_b}, 32'h0);
        chk({tag, " pass"}, 32'(pass), 32'(exp_pass));
        chk({tag, " fail_gate"}, 32'(fail_gate), 32'(exp_fg));
        chk({tag, " first_fail_vec"}, 32'(first_fail_vec), 32'(exp_ffv));
        repeat (3) begin
            @(negedge clk);
            chk({tag, " single done"}, 32'(done), 32'd0);
        end
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
        chk({tag, " hold"}, {19'd0, pass, fail_gate, 3'd0, first_fail_vec},
            {19'd0, exp_pass, exp_fg, 3'd0, exp_ffv});
    endtask

    initial begin
        int got;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset and busy", 32'(busy2), 32'd0);
        chk("reset and ffv", 32'(first_fail_vec2), 32'h1F);
        rst = 1'b0;

        mode = 2'd0;
        run("good", 0, 0, 1'b1, 4'b0000, 5'h1F);
        mode = 2'd1;
        run("stuck3", 0, 0, 1'b0, 4'b0100, 5'd11);
        mode = 2'd0;
        run("rerun", 20, 50, 1'b1, 4'b0000, 5'h1F);
        mode = 2'd2;
        run("swap", 0, 0, 1'b0, 4'b0011, 5'd3);

        // Reset at edge T+40 of a swapped run, after the failure at vector 3 was recorded
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (39) @(negedge clk);
        chk("midrun fail_gate before rst", 32'(fail_gate), 32'h3);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_idle("midrun rst");
        @(negedge clk);
        chk_idle("post rst idle");
        mode = 2'd0;
        run("after rst", 0, 0, 1'b1, 4'b0000, 5'h1F);

        mode = 2'd3;
        run("delayed", 0, 0, 1'b1, 4'b0000, 5'h1F);

        got = -1;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int k = 0; k < 200 && got < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (done2) got = k;
        end
        chk("and latency", 32'(got), 32'd85);
        chk("and pass", 32'(pass2), 32'd0);
        chk("and fail_gate", 32'(fail_gate2), 32'hF);
        chk("and first_fail_vec", 32'(first_fail_vec2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
